// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC generation, single-outstanding imem fetch,
// redirect/stall handling, 1-entry skid buffer and a registered IF/ID slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic [6:0]  if_id_opcode
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        req_fire;
  logic        rsp_take;
  logic        accept;

  // A request transfers on a cycle where imem_req_valid && imem_req_ready; valid
  // never depends on ready. Responses have no back-pressure: a response is
  // consumed on the cycle imem_rsp_valid is high while WAIT or DROP.
  assign imem_req_addr = pc;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_take      = (state == S_WAIT) && imem_rsp_valid;
  assign accept        = !stall || !if_id_valid;
  assign if_id_opcode  = if_id_instr[6:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state     = state;
    imem_req_valid = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_valid = !skid_valid && !redirect_valid;
        if (imem_req_valid && imem_req_ready) next_state = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) next_state = imem_rsp_valid ? S_FETCH : S_DROP;
        else if (imem_rsp_valid) next_state = S_FETCH;
      end
      S_DROP: begin
        // The discarded response is consumed even if another redirect lands on it.
        if (imem_rsp_valid) next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
    if (reset) imem_req_valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      inflight_pc    <= 32'd0;
      skid_valid     <= 1'b0;
      skid_pc        <= 32'd0;
      skid_instr     <= NOP_INSTR;
      if_id_valid    <= 1'b0;
      if_id_pc       <= 32'd0;
      if_id_pc_plus4 <= 32'd4;
      if_id_instr    <= NOP_INSTR;
    end else if (redirect_valid) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      skid_valid  <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else begin
      if (req_fire) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
      if (accept) begin
        if (skid_valid) begin
          if_id_valid    <= 1'b1;
          if_id_pc       <= skid_pc;
          if_id_pc_plus4 <= skid_pc + 32'd4;
          if_id_instr    <= skid_instr;
          skid_valid     <= rsp_take;
          if (rsp_take) begin
            skid_pc    <= inflight_pc;
            skid_instr <= imem_rsp_data;
          end
        end else if (rsp_take) begin
          if_id_valid    <= 1'b1;
          if_id_pc       <= inflight_pc;
          if_id_pc_plus4 <= inflight_pc + 32'd4;
          if_id_instr    <= imem_rsp_data;
        end else begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
      end else if (rsp_take) begin
        skid_valid <= 1'b1;
        skid_pc    <= inflight_pc;
        skid_instr <= imem_rsp_data;
      end
    end
  end

endmodule
